// File: rtl/core_trace_buffer.sv
// core_trace_buffer
//   Synthesisable trace capture of core writeback/store events. Multi-channel
//   event strobes feed a DEPTH-entry circular buffer of timestamped entries.
//   Capture flow: ARM -> ARMED (pre-trigger history) -> TRIGGERED (post-trigger
//   window) -> DONE (frozen, drained in order through a registered read port).
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_arm, i_clear      start capture (IDLE only) / abort and flush (any state)
//   i_post_count        entries to capture after the trigger, sampled on ARM
//   i_ch_valid/tag/data per-channel event strobe, 5-bit tag, data
//   i_trig_tag/data/mask trigger compare (mask=0 gives a tag-only trigger)
//   i_rd_en             pop oldest entry while DONE
//   o_rd_valid/o_rd_data popped entry {ts, ch_id, tag, data}, one cycle later
//   o_state             0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//   o_count, o_empty    entries held (saturates at DEPTH), count==0
//   o_drops             events lost to same-cycle collisions, saturating
module core_trace_buffer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 256,
   parameter  int CHANNELS   = 2,
   parameter  int TS_WIDTH   = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int EW = TS_WIDTH + CW + 5 + DATA_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_arm,
   input  logic                         i_clear,
   input  logic [AW:0]                  i_post_count,
   input  logic [CHANNELS-1:0]          i_ch_valid,
   input  logic [CHANNELS*5-1:0]        i_ch_tag,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_ch_data,
   input  logic [4:0]                   i_trig_tag,
   input  logic [DATA_WIDTH-1:0]        i_trig_data,
   input  logic [DATA_WIDTH-1:0]        i_trig_mask,
   input  logic                         i_rd_en,
   output logic                         o_rd_valid,
   output logic [EW-1:0]                o_rd_data,
   output logic [1:0]                   o_state,
   output logic [AW:0]                  o_count,
   output logic [15:0]                  o_drops,
   output logic                         o_empty
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRIG  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [EW-1:0]         r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [AW:0]           r_count, r_post_lat, r_post_cnt;
   logic [15:0]           r_drops;
   logic [TS_WIDTH-1:0]   r_ts;
   logic                  r_rd_valid;
   logic [EW-1:0]         r_rd_data;

   logic [CW-1:0]         w_sel;
   logic [4:0]            w_tag;
   logic [DATA_WIDTH-1:0] w_data;
   logic [3:0]            w_nvalid;
   logic                  w_any, w_match, w_capture, w_arm, w_pop, w_running;
   logic [16:0]           w_drops_sum;
   logic [15:0]           w_drops_nxt;

   // Lowest-index valid channel wins the single write slot; scanning from the
   // top down lets the last assignment be the lowest index.
   always_comb begin
      w_sel    = '0;
      w_tag    = '0;
      w_data   = '0;
      w_nvalid = '0;
      for (int i = CHANNELS-1; i >= 0; i--) begin
         if (i_ch_valid[i]) begin
            w_sel  = CW'(i);
            w_tag  = i_ch_tag[5*i +: 5];
            w_data = i_ch_data[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
      for (int i = 0; i < CHANNELS; i++)
         w_nvalid = w_nvalid + 4'(i_ch_valid[i]);
   end

   assign w_any     = |i_ch_valid;
   assign w_running = (r_state == S_ARMED) || (r_state == S_TRIG);
   assign w_match   = (w_tag == i_trig_tag) &&
                      (((w_data ^ i_trig_data) & i_trig_mask) == '0);
   // CLEAR overrides every same-cycle action.
   assign w_capture = w_any && w_running && !i_clear;
   assign w_arm     = i_arm && !i_clear && (r_state == S_IDLE);
   assign w_pop     = i_rd_en && !i_clear && (r_state == S_DONE) && (r_count != '0);

   // Every valid channel beyond the captured one is a drop.
   assign w_drops_sum = {1'b0, r_drops} + 17'(w_nvalid) - 17'd1;
   assign w_drops_nxt = w_drops_sum[16] ? 16'hFFFF : w_drops_sum[15:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (i_arm) w_state_nxt = S_ARMED;
            S_ARMED: if (w_any && w_match)
                        w_state_nxt = (r_post_lat == '0) ? S_DONE : S_TRIG;
            S_TRIG:  if (w_any && (r_post_cnt == (AW+1)'(1))) w_state_nxt = S_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drops    <= '0;
         r_ts       <= '0;
         r_post_lat <= '0;
         r_post_cnt <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (w_arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drops    <= '0;
            r_ts       <= '0;
            r_post_lat <= i_post_count;
         end else begin
            if (w_running) r_ts <= r_ts + 1'b1;
            if (w_capture) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
               // Full buffer: overwrite oldest, so the read side moves with it.
               if (r_count == (AW+1)'(DEPTH)) r_rd_ptr <= r_rd_ptr + 1'b1;
               else                           r_count  <= r_count + 1'b1;
               r_drops <= w_drops_nxt;
               if (r_state == S_ARMED && w_match) r_post_cnt <= r_post_lat;
               else if (r_state == S_TRIG)       r_post_cnt <= r_post_cnt - 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
               r_count  <= r_count - 1'b1;
            end
         end
      end
   end

   // Storage kept reset-free so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (w_capture) r_mem[r_wr_ptr] <= {r_ts, w_sel, w_tag, w_data};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)      r_rd_data <= '0;
      else if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_state    = r_state;
   assign o_count    = r_count;
   assign o_drops    = r_drops;
   assign o_empty    = (r_count == '0);

endmodule
